// File: rtl/mips_bus_pkg.sv
// Shared types and bus widths for the MIPS memory-bus arbiter.
// The state encoding doubles as the one-hot grant vector.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-style RAM slave,
// with a per-transfer wait watchdog that aborts a stuck slave.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,

  output logic [DATA_W-1:0] m_readdata,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,

  output logic [1:0]        grant,
  output logic              timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  arb_state_t       state_next;
  logic             last_m1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  logic req0;
  logic req1;
  logic gnt_req;
  logic complete;
  logic abort;
  logic done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    gnt_req = 1'b0;
    if (state == GNT_M0) gnt_req = req0;
    else if (state == GNT_M1) gnt_req = req1;
  end

  // Abort fires only once the full wait budget is spent and the slave still stalls.
  assign complete = gnt_req & ~s_waitrequest;
  assign abort    = gnt_req & s_waitrequest & (wait_cnt == CNT_MAX);
  assign done     = complete | abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_next = last_m1 ? GNT_M0 : GNT_M1;
        else if (req0)     state_next = GNT_M0;
        else if (req1)     state_next = GNT_M1;
      end
      GNT_M0: begin
        if (!req0)         state_next = IDLE;
        else if (done)     state_next = req1 ? GNT_M1 : IDLE;
      end
      GNT_M1: begin
        if (!req1)         state_next = IDLE;
        else if (done)     state_next = req0 ? GNT_M0 : IDLE;
      end
      default:             state_next = IDLE;
    endcase
  end

  // Any state change restarts the watchdog, so each grant starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_m1   <= 1'b1;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (done) last_m1 <= (state == GNT_M1);
      if (state_next != state)
        wait_cnt <= '0;
      else if (state != IDLE && s_waitrequest && wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (abort) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      GNT_M0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~abort;
        s_write        = m0_write & ~abort;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest & ~abort;
      end
      GNT_M1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~abort;
        s_write        = m1_write & ~abort;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest & ~abort;
      end
      default: ;
    endcase
  end

  assign m_readdata = s_readdata;
  assign grant      = state;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: a small RAM model with programmable
// stalls, per-master transfer tasks, and a negedge monitor that pops expectations.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam logic [31:0] BOOT_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] BOOT_WORD = 32'h2402_0005;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          master;
    bit          is_read;
    logic [31:0] rdata;
    bit          abort;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [16];
  logic [31:0] rd_word, wr_merged;
  logic        in_ram;
  int          stall_req = 0;
  bit          stall_forever = 1'b0;
  int          stall_used;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
    .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout(timeout)
  );

  // RAM model: 16 words at address 0, plus a fixed boot word at the reset vector.
  always_comb begin
    in_ram = (s_address[31:6] == 26'd0);
    rd_word = 32'h0;
    if (s_address == BOOT_ADDR) rd_word = BOOT_WORD;
    else if (in_ram)            rd_word = mem[s_address[5:2]];
    wr_merged = rd_word;
    for (int b = 0; b < 4; b++)
      if (s_byteenable[b]) wr_merged[8*b +: 8] = s_writedata[8*b +: 8];
    s_readdata    = s_read ? rd_word : 32'h0;
    s_waitrequest = stall_forever || (stall_used < stall_req);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_used <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (s_read || s_write) begin
      if (!s_waitrequest) stall_used <= 0;
      else                stall_used <= stall_used + 1;
      if (s_write && !s_waitrequest && in_ram) mem[s_address[5:2]] <= wr_merged;
    end
  end

  // Bus protocol checks every cycle, and scoreboard pops on each completion.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   m;
    if (!reset) begin
      vectors++;
      case (grant)
        2'b00: if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0 ||
                   s_write !== 1'b0 || s_address !== 32'h0 || s_writedata !== 32'h0 || s_byteenable !== 4'h0) begin
          miscompares++;
          $display("[TB] FAIL idle_bus: got wr0=%b wr1=%b rd=%b wr=%b addr=%h wd=%h be=%h, expected 1 1 0 0 0 0 0",
                   m0_waitrequest, m1_waitrequest, s_read, s_write, s_address, s_writedata, s_byteenable);
        end
        2'b01: if (m1_waitrequest !== 1'b1 || s_address !== m0_address || s_writedata !== m0_writedata ||
                   s_byteenable !== m0_byteenable ||
                   (!stall_forever && (s_read !== m0_read || s_write !== m0_write || m0_waitrequest !== s_waitrequest))) begin
          miscompares++;
          $display("[TB] FAIL m0_mux: got wr1=%b addr=%h rd=%b wr=%b wr0=%b, expected 1 %h %b %b %b",
                   m1_waitrequest, s_address, s_read, s_write, m0_waitrequest, m0_address, m0_read, m0_write, s_waitrequest);
        end
        2'b10: if (m0_waitrequest !== 1'b1 || s_address !== m1_address || s_writedata !== m1_writedata ||
                   s_byteenable !== m1_byteenable ||
                   (!stall_forever && (s_read !== m1_read || s_write !== m1_write || m1_waitrequest !== s_waitrequest))) begin
          miscompares++;
          $display("[TB] FAIL m1_mux: got wr0=%b addr=%h rd=%b wr=%b wr1=%b, expected 1 %h %b %b %b",
                   m0_waitrequest, s_address, s_read, s_write, m1_waitrequest, m1_address, m1_read, m1_write, s_waitrequest);
        end
        default: begin
          miscompares++;
          $display("[TB] FAIL grant_onehot: got %b, expected 00/01/10", grant);
        end
      endcase

      m = -1;
      if (grant == 2'b01 && (m0_read || m0_write) && m0_waitrequest === 1'b0) m = 0;
      if (grant == 2'b10 && (m1_read || m1_write) && m1_waitrequest === 1'b0) m = 1;
      if (m >= 0) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_unexpected: got completion for M%0d, expected none", m);
        end else begin
          e = sb.pop_front();
          if (e.master != m) begin
            miscompares++;
            $display("[TB] FAIL sb_master: got M%0d, expected M%0d", m, e.master);
          end else if (e.abort && (s_read !== 1'b0 || s_write !== 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL sb_abort_strobe: got rd=%b wr=%b, expected 0 0", s_read, s_write);
          end else if (!e.abort && e.is_read && m_readdata !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL sb_rdata: got %h, expected %h", m_readdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic m0_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int waits);
    bit done = 1'b0;
    waits = 0;
    m0_address = addr; m0_writedata = data; m0_byteenable = be;
    m0_read = !wr; m0_write = wr;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m0_waitrequest === 1'b0) begin done = 1'b1; break; end
      waits++;
      @(posedge clk); #1;
    end
    if (done) begin @(posedge clk); #1; end
    else begin
      vectors++; miscompares++;
      $display("[TB] FAIL m0_budget: got no completion in 40 cycles, expected completion");
    end
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
  endtask

  task automatic m1_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int waits);
    bit done = 1'b0;
    waits = 0;
    m1_address = addr; m1_writedata = data; m1_byteenable = be;
    m1_read = !wr; m1_write = wr;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m1_waitrequest === 1'b0) begin done = 1'b1; break; end
      waits++;
      @(posedge clk); #1;
    end
    if (done) begin @(posedge clk); #1; end
    else begin
      vectors++; miscompares++;
      $display("[TB] FAIL m1_budget: got no completion in 40 cycles, expected completion");
    end
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic push_exp(input int master, input bit is_read, input logic [31:0] rdata, input bit abort);
    exp_t e;
    e.master = master; e.is_read = is_read; e.rdata = rdata; e.abort = abort;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b, expected 00", grant); end
    vectors++;
    if (s_read !== 1'b0 || s_write !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_strobes: got rd=%b wr=%b, expected 0 0", s_read, s_write);
    end
    vectors++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_wait: got %b %b, expected 1 1", m0_waitrequest, m1_waitrequest);
    end
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %b, expected 0", timeout); end
    @(posedge clk); #1;
  endtask

  task automatic test_tie(input string tag);
    int w0, w1;
    push_exp(0, 1'b1, BOOT_WORD, 1'b0);
    push_exp(1, 1'b1, 32'h0, 1'b0);
    fork
      m0_xfer(1'b0, BOOT_ADDR, 32'h0, 4'hF, w0);
      m1_xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, w1);
    join
    vectors++;
    if (w0 != 1 || w1 != 2) begin
      miscompares++;
      $display("[TB] FAIL %s: got waits m0=%0d m1=%0d, expected 1 2", tag, w0, w1);
    end
  endtask

  task automatic test_m0_solo();
    int w;
    push_exp(0, 1'b1, BOOT_WORD, 1'b0);
    m0_xfer(1'b0, BOOT_ADDR, 32'h0, 4'hF, w);
    vectors++;
    if (w != 1) begin miscompares++; $display("[TB] FAIL m0_solo_waits: got %0d, expected 1", w); end
  endtask

  task automatic test_m1_write_wait();
    int w;
    stall_req = 3;
    push_exp(1, 1'b0, 32'h0, 1'b0);
    m1_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, w);
    vectors++;
    if (w != 4) begin miscompares++; $display("[TB] FAIL m1_wait_waits: got %0d, expected 4", w); end
    stall_req = 0;
    push_exp(1, 1'b0, 32'h0, 1'b0);
    m1_xfer(1'b1, 32'h0000_0014, 32'h1122_3344, 4'b0011, w);
    push_exp(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    m0_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, w);
    push_exp(0, 1'b1, 32'h0000_3344, 1'b0);
    m0_xfer(1'b0, 32'h0000_0014, 32'h0, 4'hF, w);
  endtask

  task automatic test_back_to_back();
    int w;
    push_exp(0, 1'b1, BOOT_WORD, 1'b0);
    m0_xfer(1'b0, BOOT_ADDR, 32'h0, 4'hF, w);
    push_exp(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    m0_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, w);
    vectors++;
    if (w != 1) begin miscompares++; $display("[TB] FAIL back_to_back_waits: got %0d, expected 1", w); end
  endtask

  task automatic test_timeout();
    int w;
    stall_forever = 1'b1;
    push_exp(0, 1'b1, 32'h0, 1'b1);
    m0_xfer(1'b0, BOOT_ADDR, 32'h0, 4'hF, w);
    stall_forever = 1'b0;
    vectors++;
    if (w != MAX_WAIT + 1) begin
      miscompares++; $display("[TB] FAIL timeout_waits: got %0d, expected %0d", w, MAX_WAIT + 1);
    end
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b1 || grant !== 2'b00) begin
      miscompares++; $display("[TB] FAIL timeout_flag: got to=%b grant=%b, expected 1 00", timeout, grant);
    end
    @(posedge clk); #1;
    push_exp(1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    m1_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, w);
    vectors++;
    if (w != 1 || timeout !== 1'b1) begin
      miscompares++; $display("[TB] FAIL timeout_recover: got waits=%0d to=%b, expected 1 1", w, timeout);
    end
  endtask

  task automatic test_reset_mid();
    test_m0_solo();
    stall_req = 10;
    m1_address = 32'h0000_0020; m1_writedata = 32'h5; m1_byteenable = 4'hF; m1_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 2'b10 || s_write !== 1'b1) begin
      miscompares++; $display("[TB] FAIL mid_granted: got grant=%b wr=%b, expected 10 1", grant, s_write);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (grant !== 2'b00 || s_write !== 1'b0 || m1_waitrequest !== 1'b1 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got grant=%b wr=%b wr1=%b to=%b, expected 00 0 1 0",
               grant, s_write, m1_waitrequest, timeout);
    end
    m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    stall_req = 0;
    @(posedge clk); #1 reset = 1'b0;
    test_tie("tie_post_reset");
  endtask

  initial begin
    test_reset();
    test_tie("tie_first");
    test_tie("tie_second");
    test_m0_solo();
    test_m1_write_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("[TB] FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
